// File: rtl/game_pkg.sv
// Shared game constants, ball size classes and the event-manager FSM state type.
package game_pkg;

  // Ball slot layout: slot 0 is the huge ball, slots 1-2 big, slots 3 and up medium.
  localparam int HUGE_IDX  = 0;
  localparam int BIG_FIRST = 1;
  localparam int MED_FIRST = 3;

  typedef enum logic [1:0] {
    SZ_HUGE,
    SZ_BIG,
    SZ_MEDIUM
  } size_e;

  typedef enum logic {
    COLLECT,
    RESOLVE
  } state_e;

  function automatic size_e idx_to_size(input int idx);
    if (idx == HUGE_IDX) begin
      return SZ_HUGE;
    end else if (idx >= BIG_FIRST && idx < MED_FIRST) begin
      return SZ_BIG;
    end else begin
      return SZ_MEDIUM;
    end
  endfunction

endpackage

// File: rtl/hit_priority_encoder.sv
// Lowest-index-wins priority encoder: request vector to one-hot grant, index and valid.
module hit_priority_encoder #(
  parameter int N  = 7,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Isolate the lowest set bit; scan downwards so the lowest index is written last.
  always_comb begin
    onehot_o = vec_i & (~vec_i + N'(1));
    valid_o  = |vec_i;
    idx_o    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/ball_hit_event_manager.sv
// Frame-level resolver for ball collisions: latches pixel strobes during a frame
// and turns them into at most one ball hit plus one player hit per frame.
module ball_hit_event_manager
  import game_pkg::*;
#(
  parameter int NUM_BALLS     = 7,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int SCORE_HUGE    = 10,
  parameter int SCORE_BIG     = 20,
  parameter int SCORE_MEDIUM  = 40
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [NUM_BALLS-1:0] col_player,
  input  logic [NUM_BALLS-1:0] col_rope,
  input  logic [NUM_BALLS-1:0] ball_alive,
  output logic [NUM_BALLS-1:0] ballHit,
  output logic                 ropeRetract,
  output logic                 playerHit,
  output logic                 scoreValid,
  output logic [7:0]           scoreAdd,
  output logic [2:0]           lives,
  output logic                 invulnerable,
  output logic                 gameOver
);

  localparam int IW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

  state_e               state_q, state_d;
  logic [NUM_BALLS-1:0] rope_latch_q, rope_latch_d;
  logic [NUM_BALLS-1:0] player_latch_q, player_latch_d;
  logic [NUM_BALLS-1:0] rope_snap_q, rope_snap_d;
  logic [NUM_BALLS-1:0] player_snap_q, player_snap_d;
  logic                 inv_snap_q, inv_snap_d;
  logic [7:0]           inv_cnt_q, inv_cnt_d;
  logic [2:0]           lives_q, lives_d;
  logic                 game_over_q, game_over_d;
  logic [NUM_BALLS-1:0] ball_hit_q, ball_hit_d;
  logic                 rope_retract_q, rope_retract_d;
  logic                 player_hit_q, player_hit_d;
  logic                 score_valid_q, score_valid_d;
  logic [7:0]           score_add_q, score_add_d;

  logic [NUM_BALLS-1:0] rope_mask, player_mask;
  logic [NUM_BALLS-1:0] rope_onehot;
  logic [IW-1:0]        rope_idx;
  logic                 rope_valid;

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  function automatic logic [7:0] size_score(input size_e sz);
    case (sz)
      SZ_HUGE: return 8'(SCORE_HUGE);
      SZ_BIG:  return 8'(SCORE_BIG);
      default: return 8'(SCORE_MEDIUM);
    endcase
  endfunction

  assign rope_mask   = col_rope & ball_alive;
  assign player_mask = col_player & ball_alive;

  hit_priority_encoder #(
    .N (NUM_BALLS),
    .IW(IW)
  ) u_rope_prio (
    .vec_i   (rope_snap_q),
    .onehot_o(rope_onehot),
    .idx_o   (rope_idx),
    .valid_o (rope_valid)
  );

  // FSM sequencing plus frame latching/snapshot of collisions.
  // Invulnerability is snapshotted at the boundary too, so a frame's player
  // collisions are judged against the protection that was live while they occurred.
  always_comb begin
    state_d        = state_q;
    rope_latch_d   = rope_latch_q | rope_mask;
    player_latch_d = player_latch_q | player_mask;
    rope_snap_d    = rope_snap_q;
    player_snap_d  = player_snap_q;
    inv_snap_d     = inv_snap_q;
    if (startOfFrame) begin
      rope_snap_d    = rope_latch_q;
      player_snap_d  = player_latch_q;
      inv_snap_d     = (inv_cnt_q != 8'd0);
      rope_latch_d   = rope_mask;
      player_latch_d = player_mask;
      state_d        = RESOLVE;
    end else if (state_q == RESOLVE) begin
      state_d = COLLECT;
    end
  end

  // Event resolution in RESOLVE, invulnerability countdown and life tracking.
  always_comb begin
    ball_hit_d     = '0;
    rope_retract_d = 1'b0;
    player_hit_d   = 1'b0;
    score_valid_d  = 1'b0;
    score_add_d    = 8'd0;
    lives_d        = lives_q;
    game_over_d    = game_over_q;
    inv_cnt_d      = inv_cnt_q;
    if (startOfFrame && inv_cnt_q != 8'd0) begin
      inv_cnt_d = inv_cnt_q - 8'd1;
    end
    if (state_q == RESOLVE && !game_over_q) begin
      if (rope_valid) begin
        ball_hit_d     = rope_onehot;
        rope_retract_d = 1'b1;
        score_valid_d  = 1'b1;
        score_add_d    = size_score(idx_to_size(int'(rope_idx)));
      end
      if ((|player_snap_q) && !inv_snap_q) begin
        player_hit_d = 1'b1;
        lives_d      = sat_dec(lives_q);
        inv_cnt_d    = 8'(INVULN_FRAMES);
        if (lives_d == 3'd0) begin
          game_over_d = 1'b1;
        end
      end
    end
  end

  // State, latches, counters and registered outputs; reset drops any pending frame.
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q        <= COLLECT;
      rope_latch_q   <= '0;
      player_latch_q <= '0;
      rope_snap_q    <= '0;
      player_snap_q  <= '0;
      inv_snap_q     <= 1'b0;
      inv_cnt_q      <= 8'd0;
      lives_q        <= 3'(START_LIVES);
      game_over_q    <= 1'b0;
      ball_hit_q     <= '0;
      rope_retract_q <= 1'b0;
      player_hit_q   <= 1'b0;
      score_valid_q  <= 1'b0;
      score_add_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      rope_latch_q   <= rope_latch_d;
      player_latch_q <= player_latch_d;
      rope_snap_q    <= rope_snap_d;
      player_snap_q  <= player_snap_d;
      inv_snap_q     <= inv_snap_d;
      inv_cnt_q      <= inv_cnt_d;
      lives_q        <= lives_d;
      game_over_q    <= game_over_d;
      ball_hit_q     <= ball_hit_d;
      rope_retract_q <= rope_retract_d;
      player_hit_q   <= player_hit_d;
      score_valid_q  <= score_valid_d;
      score_add_q    <= score_add_d;
    end
  end

  assign ballHit      = ball_hit_q;
  assign ropeRetract  = rope_retract_q;
  assign playerHit    = player_hit_q;
  assign scoreValid   = score_valid_q;
  assign scoreAdd     = score_add_q;
  assign lives        = lives_q;
  assign invulnerable = (inv_cnt_q != 8'd0);
  assign gameOver     = game_over_q;

endmodule

// File: doc/ball_hit_event_manager.md
Name: ball_hit_event_manager

Overview:
- Consumes the per-pixel player/rope vs. ball collision strobes and reduces them to at most one game event set per video frame.
- Events are ball hit (split/destroy), rope retract, player hit, score add and lives/game-over tracking.
- Sits between the ball collision detector and the ball-split / score / player-control logic; it is the frame-level resolver for the detector's outputs.

Parameters:
- NUM_BALLS, 7, ball slots. Index 0 = huge, 1-2 = big, 3-6 = medium.
- START_LIVES, 3, lives loaded at reset (1..7).
- INVULN_FRAMES, 60, frames a player hit is ignored after a hit (1..255).
- SCORE_HUGE, 10, points for a rope hit on index 0.
- SCORE_BIG, 20, points for a rope hit on index 1-2.
- SCORE_MEDIUM, 40, points for a rope hit on index 3-6.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-high reset (asserted = 1).
- startOfFrame  in  1  one-cycle frame-boundary strobe.
- col_player  in  NUM_BALLS  per-ball player collision strobes (pixel level).
- col_rope  in  NUM_BALLS  per-ball rope collision strobes (pixel level).
- ball_alive  in  NUM_BALLS  ball slot currently active.
- ballHit  out  NUM_BALLS  one-hot, one-cycle pulse: split/destroy this ball.
- ropeRetract  out  1  one-cycle pulse: kill the current rope.
- playerHit  out  1  one-cycle pulse: player lost a life.
- scoreValid  out  1  one-cycle pulse qualifying scoreAdd.
- scoreAdd  out  8  points to add; 0 when scoreValid = 0.
- lives  out  3  remaining lives.
- invulnerable  out  1  high while the invulnerability counter is nonzero.
- gameOver  out  1  sticky, set when lives reach 0.

Behaviour:
- Reset values: all pulses 0, scoreAdd 0, lives = START_LIVES, invulnerable 0, gameOver 0. FSM goes to COLLECT; latches and counters are cleared. Reset asserted mid-frame discards all pending latches.
- Latching (COLLECT): ropeLatch[i] |= col_rope[i] & ball_alive[i]; playerLatch[i] |= col_player[i] & ball_alive[i]. Strobes on dead balls are ignored.
- Frame boundary, cycle T with startOfFrame = 1:
  - At the edge ending T, snapshot <= latches (collisions of T excluded).
  - Latches <= only the cycle-T masked strobes, so those belong to the new frame.
  - FSM -> RESOLVE.
- RESOLVE (cycle T+1), decision made from the snapshot:
  - Rope hit: the lowest index i with ropeSnap[i] = 1 wins. The ballHit[i] pulse, ropeRetract and scoreValid are all high in cycle T+2. scoreAdd is the size-class value. Other rope snapshot bits in that frame are dropped.
  - Player hit: fires if any playerSnap bit is set AND invulnerable = 0 AND gameOver = 0. Effects:
    - playerHit pulses in T+2.
    - lives decrements in T+2, saturating at 0.
    - The invulnerability counter loads INVULN_FRAMES.
  - Player hit while invulnerable is ignored: no pulse, no decrement.
  - Rope hit and player hit in the same frame: both are processed in T+2.
  - FSM returns to COLLECT at T+2. Total latency from frame strobe to event pulses is 2 cycles.
- Invulnerability counter:
  - Decrements by 1 on each startOfFrame while nonzero.
  - invulnerable = (counter != 0).
  - A load in RESOLVE overrides any decrement.
- gameOver:
  - Set in the same cycle lives becomes 0.
  - Once set, suppresses all further pulses (ballHit, ropeRetract, playerHit, scoreValid).
  - Cleared only by reset.
- Frame strobe during RESOLVE (back-to-back frames): RESOLVE completes normally. The strobe takes a new snapshot and re-enters RESOLVE the following cycle; no event is lost.
- All outputs are registered. No combinational input-to-output path.

Decomposition:
- Shared package game_pkg:
  - ball index constants (HUGE_IDX = 0, BIG_FIRST = 1, MED_FIRST = 3).
  - size-class enum {SZ_HUGE, SZ_BIG, SZ_MEDIUM} and a function idx_to_size.
  - FSM state typedef {COLLECT, RESOLVE}.
- One sub-module: hit_priority_encoder (NUM_BALLS-bit vector -> one-hot plus valid), reused later for the small-ball slots.

Test Plan:
- Single rope hit:
  - Stimulus: col_rope[0] for 5 cycles mid-frame, ball_alive = 7'h7F, then startOfFrame at T.
  - Response: in T+2, ballHit = 7'b0000001, ropeRetract = 1, scoreValid = 1, scoreAdd = 10, each for exactly 1 cycle.
- Multi rope hit:
  - Stimulus: col_rope[5] and col_rope[2] in the same frame.
  - Response: only ballHit[2] pulses, scoreAdd = 20; bit 5 is dropped and no pulse occurs in the next frame.
- Player hit and invulnerability (INVULN_FRAMES = 3):
  - Stimulus: col_player[3] in frame 1 and again in frames 2-4.
  - Response: frame 1 gives playerHit, lives 3->2. Frames 2-4 are ignored. A hit in frame 5 gives lives 2->1.
- Game over:
  - Stimulus: three unprotected player hits.
  - Response: lives = 0 and gameOver = 1. A subsequent col_rope[0] produces no ballHit and no scoreValid.
- Boundary cases:
  - Strobe on a dead ball (ball_alive[4] = 0, col_rope[4] = 1): no event.
  - col_rope[1] asserted only in the startOfFrame cycle: the event resolves at the next frame, not the current one.
- Reset mid-frame:
  - Stimulus: latch col_rope[0] and col_player[6], assert resetN = 1 for 2 cycles, release, then startOfFrame.
  - Response: no pulses, lives = 3, invulnerable = 0.
